// File: rtl/fb_arbiter_pkg.sv
// Shared constants and types for the framebuffer arbiter.
// Geometry follows the 640x480@60 VGA timing with a 4x scaled framebuffer.
package fb_arbiter_pkg;

    localparam int FB_W       = 160;
    localparam int FB_H       = 120;
    localparam int SCALE      = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int H_VISIBLE  = 640;
    localparam int V_VISIBLE  = 480;
    localparam int H_TOTAL    = 800;
    localparam int V_TOTAL    = 525;
    localparam int FB_WORDS   = 19200;

    typedef logic [11:0] pixel_t;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

    typedef struct packed {
        logic [14:0] addr;
        pixel_t      data;
    } wr_entry_t;

    // Constant multiply built from shifted adds of the set bits of k.
    function automatic logic [14:0] mul_const(input logic [7:0] a, input int k);
        logic [14:0] s;
        s = '0;
        for (int b = 0; b < 15; b++) begin
            if (k[b]) s = s + (15'(a) << b);
        end
        return s;
    endfunction

endpackage

// File: rtl/fb_wr_fifo.sv
// Synchronous FIFO holding pending framebuffer writes.
// Simultaneous push and pop keep the count unchanged.
module fb_wr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 27
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LASTP = AW'(DEPTH - 1);
    localparam logic [AW:0]   FULLC = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == FULLC);
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = (wr_ptr_q == LASTP) ? '0 : wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = (rd_ptr_q == LASTP) ? '0 : rd_ptr_q + 1'b1;
        if (do_push && !do_pop) count_d = count_q + 1'b1;
        if (!do_push && do_pop) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/fb_arbiter.sv
// Single-port framebuffer arbiter: video fetch first, then clear, then queued writes.
// Fetches run two pixels ahead so the pixel register lines up with the beam.
module fb_arbiter #(
    parameter int FB_W       = fb_arbiter_pkg::FB_W,
    parameter int FB_H       = fb_arbiter_pkg::FB_H,
    parameter int SCALE      = fb_arbiter_pkg::SCALE,
    parameter int FIFO_DEPTH = fb_arbiter_pkg::FIFO_DEPTH
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        video_on,
    input  logic        wr_valid,
    input  logic [14:0] wr_addr,
    input  logic [11:0] wr_data,
    output logic        wr_ready,
    input  logic        clr_req,
    input  logic [11:0] clr_color,
    output logic        clr_busy,
    output logic        clr_done,
    output logic        addr_err,
    output logic        mem_en,
    output logic        mem_we,
    output logic [14:0] mem_addr,
    output logic [11:0] mem_wdata,
    input  logic [11:0] mem_rdata,
    output logic [11:0] rgb
);

    import fb_arbiter_pkg::pixel_t;
    import fb_arbiter_pkg::state_e;
    import fb_arbiter_pkg::IDLE;
    import fb_arbiter_pkg::CLEAR;
    import fb_arbiter_pkg::wr_entry_t;
    import fb_arbiter_pkg::mul_const;
    import fb_arbiter_pkg::H_TOTAL;
    import fb_arbiter_pkg::V_TOTAL;

    localparam int SH = $clog2(SCALE);
    localparam logic [10:0] HT    = 11'(H_TOTAL);
    localparam logic [9:0]  VLAST = 10'(V_TOTAL - 1);
    localparam logic [9:0]  HVIS  = 10'(FB_W * SCALE);
    localparam logic [9:0]  VVIS  = 10'(FB_H * SCALE);
    localparam logic [14:0] WORDS = 15'(FB_W * FB_H);
    localparam logic [14:0] LAST  = 15'(FB_W * FB_H - 1);

    state_e      state_q, state_d;
    logic [14:0] cnt_q, cnt_d;
    pixel_t      col_q, col_d;
    pixel_t      pix_q;
    logic        fetch_q;
    logic        err_q, err_d;

    logic [10:0] xs;
    logic        wrap;
    logic [9:0]  nx, ny;
    logic        fetch;
    logic [14:0] fetch_addr;

    assign xs    = {1'b0, x} + 11'd2;
    assign wrap  = (xs >= HT);
    assign nx    = wrap ? 10'(xs - HT) : xs[9:0];
    assign ny    = !wrap ? y : ((y == VLAST) ? 10'd0 : y + 10'd1);
    assign fetch = !reset && (nx < HVIS) && (ny < VVIS) && (nx[SH-1:0] == '0);
    assign fetch_addr = mul_const(8'(ny >> SH), FB_W) + 15'(nx >> SH);

    wr_entry_t head;
    logic      full, empty, push, pop;

    assign wr_ready = !reset && !full;
    assign push     = wr_valid && wr_ready;

    fb_wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(wr_entry_t))
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   ({wr_addr, wr_data}),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        col_d     = col_q;
        err_d     = err_q;
        pop       = 1'b0;
        clr_done  = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (!reset) begin
            if (fetch) begin
                mem_en   = 1'b1;
                mem_addr = fetch_addr;
            end else if (state_q == CLEAR) begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = cnt_q;
                mem_wdata = col_q;
                cnt_d     = cnt_q + 15'd1;
                if (cnt_q == LAST) begin
                    clr_done = 1'b1;
                    state_d  = IDLE;
                end
            end else if (!empty) begin
                pop = 1'b1;
                // Out-of-range entries are dropped rather than stalling the queue.
                if (head.addr < WORDS) begin
                    mem_en    = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = head.addr;
                    mem_wdata = head.data;
                end else begin
                    err_d = 1'b1;
                end
            end
            if (state_q == IDLE && clr_req) begin
                state_d = CLEAR;
                cnt_d   = '0;
                col_d   = clr_color;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            col_q   <= '0;
            pix_q   <= '0;
            fetch_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            col_q   <= col_d;
            fetch_q <= fetch;
            err_q   <= err_d;
            if (fetch_q) pix_q <= mem_rdata;
        end
    end

    assign clr_busy = !reset && (state_q == CLEAR);
    assign addr_err = err_q;
    assign rgb      = video_on ? pix_q : 12'h000;

endmodule

// File: tb/tb_fb_arbiter.sv
// Self-checking bench for fb_arbiter with a behavioural RAM and raster model.
// Expected values come from the raster arithmetic and a queue model.
module tb_fb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  x, y;
    logic        video_on;
    logic        wr_valid;
    logic [14:0] wr_addr;
    logic [11:0] wr_data;
    logic        wr_ready;
    logic        clr_req;
    logic [11:0] clr_color;
    logic        clr_busy, clr_done, addr_err;
    logic        mem_en, mem_we;
    logic [14:0] mem_addr;
    logic [11:0] mem_wdata;
    logic [11:0] mem_rdata;
    logic [11:0] rgb;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [11:0] ram [19200];
    logic        load_req;

    always #20 clk = ~clk;

    fb_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .x         (x),
        .y         (y),
        .video_on  (video_on),
        .wr_valid  (wr_valid),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .clr_req   (clr_req),
        .clr_color (clr_color),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done),
        .addr_err  (addr_err),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .rgb       (rgb)
    );

    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < 19200; i++) ram[i] <= 12'(i);
        end else if (mem_en && mem_we && mem_addr < 15'd19200) begin
            ram[mem_addr] <= mem_wdata;
        end
        if (mem_en && !mem_we && mem_addr < 15'd19200) mem_rdata <= ram[mem_addr];
    end

    function automatic bit slot(input int px, input int py);
        int nx, ny;
        nx = (px + 2) % 800;
        ny = (px + 2 >= 800) ? (py + 1) % 525 : py;
        return (nx < 640) && (ny < 480) && (nx % 4 == 0);
    endfunction

    function automatic int slot_addr(input int px, input int py);
        int nx, ny;
        nx = (px + 2) % 800;
        ny = (px + 2 >= 800) ? (py + 1) % 525 : py;
        return (ny / 4) * 160 + nx / 4;
    endfunction

    function automatic logic [11:0] exp_rgb(input int px, input int py);
        if (px < 640 && py < 480) return ram[(py / 4) * 160 + px / 4];
        return 12'h000;
    endfunction

    task automatic set_pos(input int px, input int py);
        x = 10'(px);
        y = 10'(py);
        video_on = (px < 640) && (py < 480);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
        if (x == 10'd799) begin
            x = 10'd0;
            y = (y == 10'd524) ? 10'd0 : y + 10'd1;
        end else begin
            x = x + 10'd1;
        end
        video_on = (x < 10'd640) && (y < 10'd480);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        wr_valid = 1'b1;
        wr_addr = 15'd5;
        wr_data = 12'h123;
        set_pos(798, 524);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total_cnt++;
            if ({mem_en, mem_we, mem_addr, mem_wdata} !== 29'd0)
                $display("FAIL rst_mem got %b/%b/%h/%h want 0", mem_en, mem_we, mem_addr, mem_wdata);
            else pass_cnt++;
            total_cnt++;
            if ({wr_ready, clr_busy, clr_done, addr_err} !== 4'b0000)
                $display("FAIL rst_flags got %b want 0000", {wr_ready, clr_busy, clr_done, addr_err});
            else pass_cnt++;
            adv();
        end
        reset = 1'b0;
        wr_valid = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (wr_ready !== 1'b1) $display("FAIL rst_ready got %b want 1", wr_ready);
        else pass_cnt++;
        total_cnt++;
        if (rgb !== 12'h000) $display("FAIL rst_rgb got %h want 000", rgb);
        else pass_cnt++;
        total_cnt++;
        if (mem_en !== 1'b0) $display("FAIL rst_noqueue got %b want 0", mem_en);
        else pass_cnt++;
        adv();
    endtask

    task automatic run_window(input int sx, input int sy, input int n);
        logic [11:0] ex;
        set_pos(sx, sy);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            total_cnt++;
            if (slot(x, y)) begin
                if (!(mem_en === 1'b1 && mem_we === 1'b0 && mem_addr === 15'(slot_addr(x, y))))
                    $display("FAIL disp_fetch x=%0d y=%0d got %b/%b/%0d want 1/0/%0d",
                             x, y, mem_en, mem_we, mem_addr, slot_addr(x, y));
                else pass_cnt++;
            end else begin
                if (mem_en !== 1'b0)
                    $display("FAIL disp_idle x=%0d y=%0d got mem_en=%b want 0", x, y, mem_en);
                else pass_cnt++;
            end
            if (i >= 6) begin
                ex = exp_rgb(x, y);
                total_cnt++;
                if (rgb !== ex) $display("FAIL disp_rgb x=%0d y=%0d got %h want %h", x, y, rgb, ex);
                else pass_cnt++;
            end
            adv();
        end
    endtask

    task automatic test_display();
        run_window(790, 524, 30);
        run_window(780, 7, 40);
        run_window(620, 479, 200);
        run_window(0, 500, 60);
        for (int k = 0; k < 6; k++) begin
            run_window($urandom_range(0, 799), $urandom_range(0, 524), 50);
        end
    endtask

    task automatic test_back_to_back();
        logic [26:0] q [$];
        logic [11:0] lastw [int];
        int sz, bad;
        bit pop_now;
        set_pos(0, 100);
        for (int i = 0; i < 330; i++) begin
            wr_valid = (i < 300) && ($urandom_range(0, 3) != 0);
            wr_addr  = 15'($urandom_range(0, 19199));
            wr_data  = 12'($urandom);
            @(negedge clk);
            sz = q.size();
            pop_now = !slot(x, y) && sz > 0;
            total_cnt++;
            if (wr_ready !== (sz < 4)) $display("FAIL b2b_ready got %b want %b", wr_ready, sz < 4);
            else pass_cnt++;
            total_cnt++;
            if (slot(x, y)) begin
                if (!(mem_en === 1'b1 && mem_we === 1'b0))
                    $display("FAIL b2b_collide x=%0d got en=%b we=%b want 1/0", x, mem_en, mem_we);
                else pass_cnt++;
            end else if (pop_now) begin
                if (!(mem_en === 1'b1 && mem_we === 1'b1 && {mem_addr, mem_wdata} === q[0]))
                    $display("FAIL b2b_pop got %b/%b/%h want 1/1/%h",
                             mem_en, mem_we, {mem_addr, mem_wdata}, q[0]);
                else pass_cnt++;
            end else begin
                if (mem_en !== 1'b0) $display("FAIL b2b_idle got %b want 0", mem_en);
                else pass_cnt++;
            end
            if (pop_now) void'(q.pop_front());
            if (wr_valid && sz < 4) begin
                q.push_back({wr_addr, wr_data});
                lastw[int'(wr_addr)] = wr_data;
            end
            adv();
        end
        bad = 0;
        foreach (lastw[a]) if (ram[a] !== lastw[a]) bad++;
        total_cnt++;
        if (bad != 0 || q.size() != 0)
            $display("FAIL b2b_ram got %0d bad words, %0d left want 0/0", bad, q.size());
        else pass_cnt++;
    endtask

    task automatic test_clear();
        logic [14:0] pa [6] = '{15'd10, 15'd10, 15'd500, 15'd19199, 15'd20, 15'd30};
        logic [11:0] pd [6] = '{12'h111, 12'h222, 12'h333, 12'h444, 12'h555, 12'h666};
        int acc, done_cnt, bad, guard, extra;
        bit fin;
        logic [11:0] ew;
        set_pos(0, 200);
        clr_req = 1'b1;
        clr_color = 12'hF00;
        adv();
        clr_req = 1'b0;
        clr_color = 12'h0F0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            wr_valid = 1'b1;
            wr_addr = pa[i];
            wr_data = pd[i];
            @(negedge clk);
            total_cnt++;
            if (wr_ready !== (acc < 4)) $display("FAIL clr_fill i=%0d got %b want %b", i, wr_ready, acc < 4);
            else pass_cnt++;
            total_cnt++;
            if (clr_busy !== 1'b1) $display("FAIL clr_busy got %b want 1", clr_busy);
            else pass_cnt++;
            if (wr_ready) acc++;
            adv();
        end
        wr_valid = 1'b0;
        done_cnt = 0;
        bad = 0;
        guard = 0;
        fin = 1'b0;
        while (!fin && guard < 30000) begin
            @(negedge clk);
            guard++;
            if (clr_done === 1'b1) begin
                done_cnt++;
                fin = 1'b1;
                if (!(mem_we === 1'b1 && mem_addr === 15'd19199)) bad++;
            end
            if (mem_we === 1'b1 && mem_wdata !== 12'hF00) bad++;
            if (mem_we === 1'b1 && slot(x, y)) bad++;
            if (clr_busy !== 1'b1) bad++;
            adv();
        end
        total_cnt++;
        if (!fin) $display("FAIL clr_timeout got no clr_done in %0d cycles want done", guard);
        else pass_cnt++;
        total_cnt++;
        if (bad != 0) $display("FAIL clr_writes got %0d bad cycles want 0", bad);
        else pass_cnt++;
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 0) begin
                total_cnt++;
                if (clr_busy !== 1'b0) $display("FAIL clr_end_busy got %b want 0", clr_busy);
                else pass_cnt++;
            end
            if (clr_done === 1'b1) extra++;
            adv();
        end
        total_cnt++;
        if (done_cnt + extra != 1) $display("FAIL clr_pulses got %0d want 1", done_cnt + extra);
        else pass_cnt++;
        bad = 0;
        for (int i = 0; i < 19200; i++) begin
            ew = (i == 10) ? 12'h222 : (i == 500) ? 12'h333 : (i == 19199) ? 12'h444 : 12'hF00;
            if (ram[i] !== ew) bad++;
        end
        total_cnt++;
        if (bad != 0) $display("FAIL clr_ram got %0d wrong words want 0", bad);
        else pass_cnt++;
    endtask

    task automatic test_addr_err();
        int we_seen;
        set_pos(700, 100);
        wr_valid = 1'b1;
        wr_addr = 15'd19200;
        wr_data = 12'hABC;
        @(negedge clk);
        total_cnt++;
        if (wr_ready !== 1'b1) $display("FAIL err_ready got %b want 1", wr_ready);
        else pass_cnt++;
        adv();
        wr_valid = 1'b0;
        we_seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (mem_we === 1'b1) we_seen++;
            adv();
        end
        total_cnt++;
        if (we_seen != 0) $display("FAIL err_nowrite got %0d writes want 0", we_seen);
        else pass_cnt++;
        total_cnt++;
        if (addr_err !== 1'b1) $display("FAIL err_flag got %b want 1", addr_err);
        else pass_cnt++;
        wr_valid = 1'b1;
        wr_addr = 15'd77;
        wr_data = 12'h5A5;
        adv();
        wr_valid = 1'b0;
        for (int i = 0; i < 3; i++) adv();
        @(negedge clk);
        total_cnt++;
        if (ram[77] !== 12'h5A5) $display("FAIL err_next_write got %h want 5a5", ram[77]);
        else pass_cnt++;
        total_cnt++;
        if (addr_err !== 1'b1) $display("FAIL err_sticky got %b want 1", addr_err);
        else pass_cnt++;
        adv();
    endtask

    task automatic test_reset_mid_clear();
        int guard, we_cnt, done_cnt;
        bit hit;
        set_pos(0, 300);
        clr_req = 1'b1;
        clr_color = 12'h00F;
        adv();
        clr_req = 1'b0;
        wr_valid = 1'b1;
        wr_addr = 15'd1;
        wr_data = 12'h777;
        adv();
        wr_addr = 15'd2;
        adv();
        wr_valid = 1'b0;
        hit = 1'b0;
        guard = 0;
        while (!hit && guard < 10000) begin
            @(negedge clk);
            guard++;
            if (mem_we === 1'b1 && mem_addr === 15'd5000) hit = 1'b1;
            else adv();
        end
        total_cnt++;
        if (!hit) $display("FAIL mrst_timeout got no write to 5000 in %0d cycles want hit", guard);
        else pass_cnt++;
        adv();
        reset = 1'b1;
        @(negedge clk);
        total_cnt++;
        if ({mem_en, mem_we, mem_addr, mem_wdata, wr_ready, clr_done} !== 31'd0)
            $display("FAIL mrst_during got %b/%b/%h/%h/%b/%b want 0",
                     mem_en, mem_we, mem_addr, mem_wdata, wr_ready, clr_done);
        else pass_cnt++;
        adv();
        reset = 1'b0;
        @(negedge clk);
        total_cnt++;
        if ({clr_busy, addr_err, rgb} !== 14'd0)
            $display("FAIL mrst_after got busy=%b err=%b rgb=%h want 0/0/000", clr_busy, addr_err, rgb);
        else pass_cnt++;
        we_cnt = 0;
        done_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (mem_we === 1'b1) we_cnt++;
            if (clr_done === 1'b1 || clr_busy === 1'b1) done_cnt++;
            adv();
        end
        total_cnt++;
        if (we_cnt != 0) $display("FAIL mrst_queue got %0d writes want 0", we_cnt);
        else pass_cnt++;
        total_cnt++;
        if (done_cnt != 0) $display("FAIL mrst_done got %0d busy/done cycles want 0", done_cnt);
        else pass_cnt++;
    endtask

    initial begin
        reset = 1'b1;
        wr_valid = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        clr_req = 1'b0;
        clr_color = '0;
        load_req = 1'b1;
        set_pos(0, 0);
        @(posedge clk);
        #1;
        load_req = 1'b0;
        test_reset();
        test_display();
        test_back_to_back();
        test_clear();
        test_addr_err();
        test_reset_mid_clear();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
